gray_fx_sched: RTL and testbench



---
 rtl/gray_fx_pkg.sv | 30 +++
 rtl/vb_rise_det.sv | 29 ++
 rtl/gray_fx_sched.sv | 144 ++++++++++++++
 tb/tb_gray_fx_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_fx_pkg.sv
// gray_fx_pkg
// Shared types and defaults for the grayscale filter enable scheduler.
//   fx_state_t      : scheduler states (IDLE, WAIT_VB, DRAIN, DONE)
//   DRAIN_CYC_DEF   : default filter pipeline depth in clocks
//   TIMEOUT_CYC_DEF : default clocks to wait for a vblank edge before forcing
//   cnt_width()     : counter width able to hold 0..n, never less than one bit
package gray_fx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } fx_state_t;

    localparam int DRAIN_CYC_DEF   = 2;
    localparam int TIMEOUT_CYC_DEF = 1000000;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/vb_rise_det.sv
// vb_rise_det
// Rising-edge detector for a blanking strobe that is already synchronous to clk.
// The delayed copy resets high so a strobe that is high when reset releases
// does not produce a spurious edge.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   vb_in   : blanking strobe
//   vb_rise : high for the cycle in which vb_in is 1 and was 0 one clock earlier
module vb_rise_det (
    input  logic clk,
    input  logic reset_n,
    input  logic vb_in,
    output logic vb_rise
);

    logic vb_q;

    // One-clock delayed copy of the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vb_q <= 1'b1;
        end else begin
            vb_q <= vb_in;
        end
    end

    assign vb_rise = vb_in & ~vb_q;

endmodule

// File: rtl/gray_fx_sched.sv
// gray_fx_sched
// Schedules changes of the grayscale filter enable so they land on a vertical
// blank rising edge, then waits out the filter pipeline before reporting done.
// If video has stopped and no edge arrives within TIMEOUT_CYC clocks of the
// request, the change is forced and timeout_flag records that.
//   clk          : video pixel clock
//   reset_n      : asynchronous active-low reset
//   req_valid    : host request valid
//   req_ready    : request accepted when high together with req_valid (idle)
//   req_enable   : requested mode, 1 = grayscale, sampled on handshake
//   vb_in        : vertical blank, synchronous to clk
//   enable_out   : filter enable
//   busy         : a request is in flight
//   done         : one-cycle pulse, requested mode active and pipeline drained
//   timeout_flag : sticky, last change was forced by the timeout
module gray_fx_sched
    import gray_fx_pkg::*;
#(
    parameter int DRAIN_CYC   = DRAIN_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_enable,
    input  logic vb_in,
    output logic enable_out,
    output logic busy,
    output logic done,
    output logic timeout_flag
);

    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int DW = cnt_width(DRAIN_CYC);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
    // With DRAIN_CYC == 0 the DRAIN state is never entered; keep the constant legal.
    localparam logic [DW-1:0] DLAST = DW'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

    fx_state_t     state_q, state_d;
    logic          enable_q, enable_d;
    logic          done_q, done_d;
    logic          tflag_q, tflag_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          vb_rise_s;

    vb_rise_det u_vb_rise_det (
        .clk     (clk),
        .reset_n (reset_n),
        .vb_in   (vb_in),
        .vb_rise (vb_rise_s)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        done_d   = 1'b0;
        tflag_d  = tflag_q;
        pend_d   = pend_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pend_d  = req_enable;
                    tflag_d = 1'b0;
                    tcnt_d  = '0;
                    // Requesting the mode already in force needs no vblank wait.
                    if (req_enable == enable_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_VB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_VB: begin
                tcnt_d = tcnt_q + TW'(1);
                if (vb_rise_s || (tcnt_q == TLAST)) begin
                    enable_d = pend_q;
                    // A real edge wins over a coincident timeout.
                    tflag_d  = ~vb_rise_s;
                    dcnt_d   = '0;
                    if (DRAIN_CYC == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = WAIT_VB;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DLAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            tflag_q  <= 1'b0;
            pend_q   <= 1'b0;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            tflag_q  <= tflag_d;
            pend_q   <= pend_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign enable_out   = enable_q;
    assign done         = done_q;
    assign timeout_flag = tflag_q;
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gray_fx_sched.sv
module tb_gray_fx_sched;

    localparam int DRAIN = 2;
    localparam int TMO   = 100;

    logic clk;
    logic reset_n;
    logic req_valid;
    logic req_ready;
    logic req_enable;
    logic vb_in;
    logic enable_out;
    logic busy;
    logic done;
    logic timeout_flag;

    int checks = 0;
    int errors = 0;

    gray_fx_sched #(
        .DRAIN_CYC   (DRAIN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_enable   (req_enable),
        .vb_in        (vb_in),
        .enable_out   (enable_out),
        .busy         (busy),
        .done         (done),
        .timeout_flag (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (event timestamps) ----------------
    // k counts clock edges. A request accepted at edge h switches the mode at
    // the first vblank rise in (h, h+TMO], or is forced at h+TMO; done shows
    // after edge d = switch+DRAIN (d = h for a no-op); idle again after d+1.
    int k = 0;
    bit m_vb_prev = 1'b1;
    bit m_active = 1'b0;
    int m_h = 0;
    int m_d = -1;
    bit m_pend = 1'b0;
    bit m_en = 1'b0;
    bit m_tflag = 1'b0;
    bit e_done = 1'b0;
    bit e_busy = 1'b0;

    task automatic model_reset();
        m_vb_prev = 1'b1;
        m_active  = 1'b0;
        m_d       = -1;
        m_en      = 1'b0;
        m_tflag   = 1'b0;
        e_done    = 1'b0;
        e_busy    = 1'b0;
    endtask

    task automatic model_step();
        bit rise;
        k++;
        rise = vb_in && !m_vb_prev;
        m_vb_prev = vb_in;
        if (m_active && m_d >= 0 && k >= m_d + 2) m_active = 1'b0;
        if (!m_active) begin
            if (req_valid) begin
                m_active = 1'b1;
                m_h      = k;
                m_pend   = req_enable;
                m_tflag  = 1'b0;
                m_d      = (req_enable == m_en) ? k : -1;
            end
        end else if (m_d < 0) begin
            if (rise || k == m_h + TMO) begin
                m_en    = m_pend;
                m_tflag = !rise;
                m_d     = k + DRAIN;
            end
        end
        e_done = m_active && (k == m_d);
        e_busy = m_active && (m_d < 0 || k <= m_d);
    endtask

    always @(negedge reset_n) model_reset();

    // Model update on each edge, then compare every output shortly after.
    always @(posedge clk) begin
        if (reset_n) model_step();
        #1;
        if (reset_n) begin
            chk("m_enable_out", enable_out, m_en);
            chk("m_timeout_flag", timeout_flag, m_tflag);
            chk("m_done", done, e_done);
            chk("m_busy", busy, e_busy);
            chk("m_req_ready", req_ready, !e_busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        bit ok;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_enable = 1'b0;
        vb_in      = 1'b1;
        #1;
        chk("rst_enable", enable_out, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tflag", timeout_flag, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // No-op request: enable 0 while already 0.
        req_valid = 1'b1; req_enable = 1'b0;
        step();
        req_valid = 1'b0;
        chk("noop_done", done, 1'b1);
        chk("noop_enable", enable_out, 1'b0);
        chk("noop_ready_low", req_ready, 1'b0);
        step();
        chk("noop_done_end", done, 1'b0);
        chk("noop_ready_back", req_ready, 1'b1);

        // vb held high: no change until a genuine rise.
        req_valid = 1'b1; req_enable = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t1_busy", busy, 1'b1);
        ok = 1'b1;
        repeat (50) begin
            step();
            if (enable_out !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        chk("t1_hold_50", ok, 1'b1);
        vb_in = 1'b0; step();
        vb_in = 1'b1; step();
        chk("t1_enable_on_rise", enable_out, 1'b1);
        chk("t1_tflag", timeout_flag, 1'b0);
        step();
        chk("t1_done_early", done, 1'b0);
        step();
        chk("t1_done", done, 1'b1);
        step();
        chk("t1_done_end", done, 1'b0);
        chk("t1_ready", req_ready, 1'b1);

        // Timeout with vb held low.
        vb_in = 1'b0; req_valid = 1'b1; req_enable = 1'b0;
        step();
        req_valid = 1'b0;
        n = 0;
        while (enable_out === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk_int("t3_timeout_edges", n, 100);
        chk("t3_tflag", timeout_flag, 1'b1);
        step();
        chk("t3_done_early", done, 1'b0);
        step();
        chk("t3_done", done, 1'b1);
        step();

        // Rise coincident with timeout; a second request is held throughout.
        req_valid = 1'b1; req_enable = 1'b1;
        step();
        req_enable = 1'b0;
        chk("t4_tflag_cleared", timeout_flag, 1'b0);
        ok = 1'b1;
        repeat (99) begin
            step();
            if (req_ready !== 1'b0) ok = 1'b0;
        end
        chk("t4_enable_before", enable_out, 1'b0);
        vb_in = 1'b1;
        step();
        chk("t4_enable_edge", enable_out, 1'b1);
        chk("t4_tflag_edge_wins", timeout_flag, 1'b0);
        step();
        if (req_ready !== 1'b0) ok = 1'b0;
        step();
        if (req_ready !== 1'b0) ok = 1'b0;
        chk("t5_done", done, 1'b1);
        chk("t5_blocked", ok, 1'b1);
        step();
        chk("t5_ready_back", req_ready, 1'b1);
        step();
        chk("t5_accepted", busy, 1'b1);
        req_valid = 1'b0;
        repeat (5) step();
        chk("t5_waiting", enable_out, 1'b1);
        vb_in = 1'b0; step();
        vb_in = 1'b1; step();
        chk("t5_enable_off", enable_out, 1'b0);
        repeat (3) step();

        // Reset in DRAIN.
        req_valid = 1'b1; req_enable = 1'b1;
        step();
        req_valid = 1'b0;
        vb_in = 1'b0; step();
        vb_in = 1'b1; step();
        chk("t6_enable_drain", enable_out, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_enable", enable_out, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            step();
            if (done !== 1'b0) ok = 1'b0;
        end
        chk("t6_no_done", ok, 1'b1);

        // Random traffic against the model.
        repeat (4000) begin
            req_valid  = ($urandom_range(0, 9) < 3);
            req_enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) vb_in = ~vb_in;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
